spi_mem_responder: RTL and testbench

//   SPI mode-0 target that emulates the serial SPI memory fetched by the SERV SPI

---
 rtl/spi_mem_responder_if.sv | 26 ++
 rtl/spi_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_responder_if.sv
// Bundles the SPI pins and the byte-wide memory port of spi_mem_responder.
// The responder uses the slave modport; the SPI master / memory side uses master.
interface spi_mem_responder_if #(
   parameter int unsigned ADDR_BITS = 24
) ();
   logic                 spi_sck;
   logic                 spi_ss;
   logic                 spi_mosi;
   logic                 spi_miso;
   logic                 spi_miso_oe;
   logic [ADDR_BITS-1:0] mem_addr;
   logic                 mem_re;
   logic [7:0]           mem_rdata;
   logic                 mem_we;
   logic [7:0]           mem_wdata;

   modport slave (
      input  spi_sck, spi_ss, spi_mosi, mem_rdata,
      output spi_miso, spi_miso_oe, mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output spi_sck, spi_ss, spi_mosi, mem_rdata,
      input  spi_miso, spi_miso_oe, mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target emulating a serial boot memory: READ (0x03) and WRITE (0x02)
// with auto-incrementing address, backed by a synchronous byte-wide memory port.
// SPI pins are asynchronous and oversampled in wb_clk.
module spi_mem_responder #(
   parameter int unsigned ADDR_BITS = 24,
   parameter int unsigned SYNC_FF   = 2
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst,
   spi_mem_responder_if.slave    bus
);

   localparam int unsigned CW = $clog2(ADDR_BITS);
   localparam logic [CW-1:0] BYTE_LAST = CW'(7);
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, IGNORE} state_t;

   state_t state, state_nxt;

   logic [SYNC_FF-1:0]   sck_sync, ss_sync, mosi_sync;
   logic                 sck_s, ss_s, mosi_s, sck_d;
   logic                 sck_rise, sck_fall, sel;

   logic [CW-1:0]        bit_cnt;
   logic [ADDR_BITS-2:0] shift_q;
   logic                 rd_type;
   logic [7:0]           tx_q;
   logic                 miso_q;
   logic                 cap_q;
   logic [ADDR_BITS-1:0] mem_addr_q;
   logic                 mem_re_q, mem_we_q;
   logic [7:0]           mem_wdata_q;

   logic                 byte_done, addr_done;
   logic [7:0]           in_byte;
   logic [ADDR_BITS-1:0] in_addr;

   // Synchronize SCK, SS and MOSI through equal-depth chains; keep the previous SCK for edge detection
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         sck_sync  <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_FF-2:0], bus.spi_sck};
         ss_sync   <= {ss_sync[SYNC_FF-2:0], bus.spi_ss};
         mosi_sync <= {mosi_sync[SYNC_FF-2:0], bus.spi_mosi};
         sck_d     <= sck_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_FF-1];
   assign ss_s     = ss_sync[SYNC_FF-1];
   assign mosi_s   = mosi_sync[SYNC_FF-1];
   assign sel      = ~ss_s;
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;

   assign byte_done = (bit_cnt == BYTE_LAST);
   assign addr_done = (bit_cnt == ADDR_LAST);
   // Value the shifter will hold once the bit sampled on this rise is included
   assign in_byte   = {shift_q[6:0], mosi_s};
   assign in_addr   = {shift_q, mosi_s};

   // State register
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: deselect overrides everything and returns to IDLE
   always_comb begin
      state_nxt = state;
      if (!sel) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = CMD;
            CMD: begin
               if (sck_rise && byte_done) begin
                  case (in_byte)
                     8'h03, 8'h02: state_nxt = ADDR;
                     default:      state_nxt = IGNORE;
                  endcase
               end
            end
            ADDR: begin
               if (sck_rise && addr_done) state_nxt = rd_type ? RD : WR;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // Datapath: shifting, bit counting, memory strobes and the read pipeline
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         bit_cnt     <= '0;
         shift_q     <= '0;
         rd_type     <= 1'b0;
         tx_q        <= '0;
         miso_q      <= 1'b0;
         cap_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         mem_re_q <= 1'b0;
         mem_we_q <= 1'b0;
         // mem_rdata is valid the cycle after mem_re; capture it then
         cap_q    <= mem_re_q;
         if (cap_q) tx_q <= bus.mem_rdata;
         // Post-increment after each write strobe; also covers a strobe that
         // overlaps deselect, since the byte was already complete
         if (mem_we_q) mem_addr_q <= mem_addr_q + ADDR_BITS'(1);

         if (!sel) begin
            bit_cnt <= '0;
            shift_q <= '0;
            rd_type <= 1'b0;
            tx_q    <= '0;
            miso_q  <= 1'b0;
            cap_q   <= 1'b0;
         end else begin
            case (state)
               CMD: begin
                  if (sck_rise) begin
                     shift_q <= {shift_q[ADDR_BITS-3:0], mosi_s};
                     if (byte_done) begin
                        bit_cnt <= '0;
                        rd_type <= (in_byte == 8'h03);
                     end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                     end
                  end
               end
               ADDR: begin
                  if (sck_rise) begin
                     shift_q <= {shift_q[ADDR_BITS-3:0], mosi_s};
                     if (addr_done) begin
                        bit_cnt    <= '0;
                        mem_addr_q <= in_addr;
                        mem_re_q   <= rd_type;
                     end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                     end
                  end
               end
               RD: begin
                  if (sck_fall) begin
                     miso_q <= tx_q[7];
                     tx_q   <= {tx_q[6:0], 1'b0};
                  end
                  // Prefetch the next byte on the rise that samples bit 0; it lands
                  // in tx_q two cycles later, well before the next fall
                  if (sck_rise) begin
                     if (byte_done) begin
                        bit_cnt    <= '0;
                        mem_addr_q <= mem_addr_q + ADDR_BITS'(1);
                        mem_re_q   <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                     end
                  end
               end
               WR: begin
                  if (sck_rise) begin
                     shift_q <= {shift_q[ADDR_BITS-3:0], mosi_s};
                     if (byte_done) begin
                        bit_cnt     <= '0;
                        mem_wdata_q <= in_byte;
                        mem_we_q    <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Outputs: enable follows synchronized select; MISO only carries data in RD
   always_comb begin
      bus.spi_miso_oe = sel;
      bus.spi_miso    = (state == RD && sel) ? miso_q : 1'b0;
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: table of READ/WRITE transactions
// plus hand-written bad-command, abort and reset-mid-read sequences.
module tb_spi_mem_responder;

   localparam int unsigned HALF = 60;   // SCK half period in ns (6 wb_clk cycles)
   localparam int unsigned SFF  = 2;

   logic wb_clk = 1'b0;
   logic wb_rst;

   spi_mem_responder_if #(.ADDR_BITS(24)) bus ();

   spi_mem_responder #(.ADDR_BITS(24), .SYNC_FF(SFF)) dut (
      .wb_clk (wb_clk),
      .wb_rst (wb_rst),
      .bus    (bus)
   );

   always #5 wb_clk = ~wb_clk;

   // Memory model: read data valid the cycle after mem_re
   logic [7:0] mem [logic [23:0]];
   always @(posedge wb_clk) begin
      if (bus.mem_re) bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 8'h00;
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
   end

   // Strobe events: kind = {we, re}
   typedef struct packed {
      logic [1:0]  kind;
      logic [23:0] addr;
      logic [7:0]  data;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];

   always @(negedge wb_clk) begin
      if (!wb_rst && (bus.mem_re || bus.mem_we))
         obs_q.push_back('{kind: {bus.mem_we, bus.mem_re}, addr: bus.mem_addr, data: bus.mem_wdata});
   end

   typedef struct packed {
      logic        wr;
      logic        pre;
      logic [23:0] addr;
      logic [2:0]  n;
      logic [31:0] d;
   } vec_t;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic drain(input string name);
      ev_t o, e;
      int n_obs = obs_q.size();
      int n_exp = exp_q.size();
      check({name, " strobe count"}, 32'(n_obs), 32'(n_exp));
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({name, " strobe kind"}, 32'(o.kind), 32'(e.kind));
         check({name, " strobe addr"}, 32'(o.addr), 32'(e.addr));
         if (e.kind == 2'b10) check({name, " write data"}, 32'(o.data), 32'(e.data));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic spi_bit(input logic b, output logic r);
      bus.spi_mosi = b;
      #(HALF);
      bus.spi_sck = 1'b1;
      r = bus.spi_miso;
      #(HALF);
      bus.spi_sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], r);
         rx[i] = r;
      end
   endtask

   task automatic ss_end();
      #(HALF);
      bus.spi_ss = 1'b1;
      #(HALF * 2);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      logic [7:0]  rx, b;
      logic [23:0] a;
      for (int k = 0; k < int'(v.n); k++) begin
         a = v.addr + 24'(k);
         b = v.d[31 - 8*k -: 8];
         if (!v.wr && v.pre) mem[a] = b;
         if (v.wr) exp_q.push_back('{kind: 2'b10, addr: a, data: b});
         else      exp_q.push_back('{kind: 2'b01, addr: a, data: 8'h00});
      end
      // Read prefetches one byte past the last one clocked out
      if (!v.wr) exp_q.push_back('{kind: 2'b01, addr: v.addr + 24'(v.n), data: 8'h00});
      bus.spi_ss = 1'b0;
      #(HALF);
      spi_byte(v.wr ? 8'h02 : 8'h03, rx);
      spi_byte(v.addr[23:16], rx);
      spi_byte(v.addr[15:8], rx);
      spi_byte(v.addr[7:0], rx);
      for (int k = 0; k < int'(v.n); k++) begin
         b = v.d[31 - 8*k -: 8];
         spi_byte(v.wr ? b : 8'h00, rx);
         if (!v.wr) check({name, " miso byte"}, 32'(rx), 32'(b));
      end
      ss_end();
      drain(name);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " spi_miso"},    32'(bus.spi_miso),    32'(0));
      check({name, " spi_miso_oe"}, 32'(bus.spi_miso_oe), 32'(0));
      check({name, " mem_re"},      32'(bus.mem_re),      32'(0));
      check({name, " mem_we"},      32'(bus.mem_we),      32'(0));
      check({name, " mem_addr"},    32'(bus.mem_addr),    32'(0));
      check({name, " mem_wdata"},   32'(bus.mem_wdata),   32'(0));
   endtask

   vec_t tbl[9];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rx;
      logic       r;
      int         cyc;

      tbl[0] = '{wr: 1'b0, pre: 1'b1, addr: 24'h000010, n: 3'd2, d: 32'hA53C_0000};
      tbl[1] = '{wr: 1'b1, pre: 1'b0, addr: 24'h0001FF, n: 3'd2, d: 32'hDEAD_0000};
      tbl[2] = '{wr: 1'b0, pre: 1'b1, addr: 24'hFFFFFF, n: 3'd2, d: 32'h1122_0000};
      tbl[3] = '{wr: 1'b0, pre: 1'b0, addr: 24'h0001FF, n: 3'd2, d: 32'hDEAD_0000};
      tbl[4] = '{wr: 1'b1, pre: 1'b0, addr: 24'hFFFFFF, n: 3'd2, d: 32'h7788_0000};
      tbl[5] = '{wr: 1'b0, pre: 1'b0, addr: 24'hFFFFFF, n: 3'd2, d: 32'h7788_0000};
      tbl[6] = '{wr: 1'b0, pre: 1'b1, addr: 24'h123456, n: 3'd4, d: 32'h0180_FF5A};
      tbl[7] = '{wr: 1'b1, pre: 1'b0, addr: 24'hABCDEF, n: 3'd1, d: 32'hC300_0000};
      tbl[8] = '{wr: 1'b0, pre: 1'b0, addr: 24'hABCDEF, n: 3'd1, d: 32'hC300_0000};

      bus.spi_sck  = 1'b0;
      bus.spi_ss   = 1'b1;
      bus.spi_mosi = 1'b0;
      wb_rst       = 1'b1;
      #23;
      check_reset_outputs("reset");
      #20;
      wb_rst = 1'b0;
      #(HALF);

      for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Unknown command: MISO stays low, no strobes, then a normal read works
      bus.spi_ss = 1'b0;
      #(HALF);
      check("badcmd miso_oe", 32'(bus.spi_miso_oe), 32'(1));
      spi_byte(8'h9F, rx);
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'hFF, rx);
         check("badcmd miso", 32'(rx), 32'(0));
      end
      ss_end();
      drain("badcmd");
      run_vec(tbl[0], "after badcmd");

      // Abort a write after 5 data bits
      bus.spi_ss = 1'b0;
      #(HALF);
      spi_byte(8'h02, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h40, rx);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
      bus.spi_ss = 1'b1;
      cyc = 0;
      while (bus.spi_miso_oe && cyc < 10) begin
         @(posedge wb_clk);
         #1;
         cyc++;
      end
      check("abort oe fall in time", 32'(cyc <= int'(SFF) + 1), 32'(1));
      @(posedge wb_clk);
      #8;
      #(HALF * 4);
      drain("abort");

      // Reset in the middle of the second read byte
      mem[24'h000040] = 8'h5A;
      mem[24'h000041] = 8'hC3;
      exp_q.push_back('{kind: 2'b01, addr: 24'h000040, data: 8'h00});
      exp_q.push_back('{kind: 2'b01, addr: 24'h000041, data: 8'h00});
      bus.spi_ss = 1'b0;
      #(HALF);
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h40, rx);
      spi_byte(8'h00, rx);
      check("rstmid byte0", 32'(rx), 32'h5A);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
      check("rstmid addr before reset", 32'(bus.mem_addr), 32'h41);
      wb_rst = 1'b1;
      #1;
      check_reset_outputs("rstmid");
      bus.spi_ss  = 1'b1;
      bus.spi_sck = 1'b0;
      #(HALF);
      #9;
      wb_rst = 1'b0;
      #(HALF);
      drain("rstmid");
      run_vec(tbl[6], "after rstmid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
